// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller
// and its output prefetch buffer.
package sram_fifo_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int ADDR_WIDTH  = 4;
    localparam int RAM_DEPTH   = 16;
    localparam int BUF_DEPTH   = 2;
    localparam int COUNT_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;
    typedef logic [1:0]             bcnt_t;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry output buffer that absorbs the SRAM read latency; entry 0 is
// always the head, entry 1 the word behind it.
module sram_fifo_outbuf
    import sram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output bcnt_t count_o,
    output data_t head_o
);
    bcnt_t cnt_q, cnt_d;
    data_t e0_q, e0_d;
    data_t e1_q, e1_d;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = data_i;
                else               e1_d = data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Pop and fill together: occupancy is unchanged, data shifts.
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = data_i;
                end else begin
                    e0_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for the 16x8 1r1w SRAM macro: writes pushes straight to the
// array and prefetches reads into a 2-entry buffer for one-word-per-cycle pops.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  data_t  in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output data_t  out_data,
    output count_t count,
    output logic   full,
    output logic   empty,
    output logic   sram_csb0,
    output addr_t  sram_addr0,
    output data_t  sram_din0,
    output logic   sram_csb1,
    output addr_t  sram_addr1,
    input  data_t  sram_dout1
);
    localparam logic [ADDR_WIDTH:0] MEM_FULL = (ADDR_WIDTH+1)'(RAM_DEPTH);

    addr_t                wptr_q, wptr_d;
    addr_t                rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]  mem_count_q, mem_count_d;
    logic                 rd_inflight_q, rd_inflight_d;
    bcnt_t                buf_count;
    data_t                buf_head;
    logic                 push_fire, pop_fire, rd_issue;
    logic [2:0]           pending;

    assign in_ready  = rst_n & (mem_count_q != MEM_FULL);
    assign full      = rst_n & (mem_count_q == MEM_FULL);
    assign out_valid = rst_n & (buf_count != 2'd0);
    assign push_fire = in_valid & in_ready;
    assign pop_fire  = out_valid & out_ready;

    // Words already committed to the buffer, counting a read still in flight.
    assign pending  = {1'b0, buf_count} + {2'b00, rd_inflight_q};
    assign rd_issue = rst_n & (mem_count_q != '0) & ((pending < 3'd2) | pop_fire);

    assign count = count_t'(mem_count_q) + count_t'(buf_count) + count_t'(rd_inflight_q);
    assign empty = (count == '0);

    assign sram_csb0  = ~push_fire;
    assign sram_addr0 = push_fire ? wptr_q  : '0;
    assign sram_din0  = push_fire ? in_data : '0;
    assign sram_csb1  = ~rd_issue;
    assign sram_addr1 = rd_issue ? rptr_q : '0;

    assign out_data = out_valid ? buf_head : '0;

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        mem_count_d   = mem_count_q;
        rd_inflight_d = rd_issue;
        if (push_fire) wptr_d = wptr_q + addr_t'(1);
        if (rd_issue)  rptr_d = rptr_q + addr_t'(1);
        case ({push_fire, rd_issue})
            2'b10:   mem_count_d = mem_count_q + 1'b1;
            2'b01:   mem_count_d = mem_count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_count_q   <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_count_q   <= mem_count_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // A read in flight across reset is dropped because rd_inflight_q clears.
    sram_fifo_outbuf u_outbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rd_inflight_q),
        .data_i  (sram_dout1),
        .pop_i   (pop_fire),
        .count_o (buf_count),
        .head_o  (buf_head)
    );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural model of the
// 1r1w SRAM macro (write at the edge, read data registered one edge later).
module tb_sram_fifo_ctrl;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       sram_csb0;
    logic [3:0] sram_addr0;
    logic [7:0] sram_din0;
    logic       sram_csb1;
    logic [3:0] sram_addr1;
    logic [7:0] sram_dout1;

    logic [7:0] ram [16];

    int n_pass = 0;
    int n_total = 0;
    int coll_errs = 0;
    int over_errs = 0;

    sram_fifo_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial sram_dout1 = 8'h00;
    always @(posedge clk) begin
        if (!sram_csb0) ram[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= ram[sram_addr1];
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1))
            else begin
                coll_errs <= coll_errs + 1;
                $display("FAIL collision: addr0=%0h addr1=%0h both selected", sram_addr0, sram_addr1);
            end
            assert (count <= 5'd18)
            else begin
                over_errs <= over_errs + 1;
                $display("FAIL count_max: count=%0d limit 18", count);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change at edge+1, outputs are sampled at edge+8.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  din;
        logic        ordy;
        logic [34:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] din,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [7:0] od, input logic [4:0] cnt, input logic fu,
                                input logic em, input logic c0, input logic [3:0] a0,
                                input logic [7:0] d0, input logic c1, input logic [3:0] a1);
        vec_t v;
        v.rst  = rst;
        v.iv   = iv;
        v.din  = din;
        v.ordy = ordy;
        v.exp  = {ir, ov, od, cnt, fu, em, c0, a0, d0, c1, a1};
        return v;
    endfunction

    vec_t vecs [13];

    task automatic run_stream(input int n, input bit backpressure, input string tag);
        logic [7:0] exp_q [$];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int first_pop = -1;
        int last_pop = 0;
        logic [7:0] e;
        while (got < n && cyc < 4000) begin
            in_valid  = (sent < n) && (backpressure ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_data   = backpressure ? 8'($urandom_range(0, 255)) : 8'(8'h40 + sent);
            out_ready = backpressure ? (cyc % 2 == 0) : 1'b1;
            #7;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_underflow"}, 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_data"}, 64'(out_data), 64'(e));
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_done"}, 64'(got), 64'(n));
        if (!backpressure) check({tag, "_rate"}, 64'(last_pop - first_pop), 64'(n - 1));
    endtask

    initial begin
        int k;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        next_cycle();
        next_cycle();

        //             rst iv din    ordy ir ov od     cnt fu em c0 a0 d0     c1 a1
        vecs[0]  = mk(0, 0, 8'h00, 0,   0, 0, 8'h00, 0,  0, 1, 1, 0, 8'h00, 1, 0);
        vecs[1]  = mk(1, 1, 8'hA5, 0,   1, 0, 8'h00, 0,  0, 1, 0, 0, 8'hA5, 1, 0);
        vecs[2]  = mk(1, 0, 8'h00, 0,   1, 0, 8'h00, 1,  0, 0, 1, 0, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 8'h00, 0,   1, 0, 8'h00, 1,  0, 0, 1, 0, 8'h00, 1, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0,   1, 1, 8'hA5, 1,  0, 0, 1, 0, 8'h00, 1, 0);
        vecs[5]  = mk(1, 0, 8'h00, 1,   1, 1, 8'hA5, 1,  0, 0, 1, 0, 8'h00, 1, 0);
        vecs[6]  = mk(1, 0, 8'h00, 0,   1, 0, 8'h00, 0,  0, 1, 1, 0, 8'h00, 1, 0);
        vecs[7]  = mk(1, 1, 8'h11, 1,   1, 0, 8'h00, 0,  0, 1, 0, 1, 8'h11, 1, 0);
        vecs[8]  = mk(1, 1, 8'h22, 1,   1, 0, 8'h00, 1,  0, 0, 0, 2, 8'h22, 0, 1);
        vecs[9]  = mk(1, 0, 8'h00, 1,   1, 0, 8'h00, 2,  0, 0, 1, 0, 8'h00, 0, 2);
        vecs[10] = mk(1, 0, 8'h00, 1,   1, 1, 8'h11, 2,  0, 0, 1, 0, 8'h00, 1, 0);
        vecs[11] = mk(1, 0, 8'h00, 1,   1, 1, 8'h22, 1,  0, 0, 1, 0, 8'h00, 1, 0);
        vecs[12] = mk(1, 0, 8'h00, 0,   1, 0, 8'h00, 0,  0, 1, 1, 0, 8'h00, 1, 0);

        for (int i = 0; i < 13; i++) begin
            rst_n     = vecs[i].rst;
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            #7;
            check($sformatf("vec%0d", i),
                  64'({in_ready, out_valid, out_data, count, full, empty,
                       sram_csb0, sram_addr0, sram_din0, sram_csb1, sram_addr1}),
                  64'(vecs[i].exp));
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Fill to 18 words with the consumer stalled.
        k = 0;
        guard = 0;
        while (k < 18 && guard < 200) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            #7;
            if (in_ready) k++;
            next_cycle();
            guard++;
        end
        check("fill_accepted", 64'(k), 64'd18);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h99;
            #7;
            check($sformatf("fill_held%0d", c), 64'({in_ready, full, count}), 64'({1'b0, 1'b1, 5'd18}));
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        guard = 0;
        while (k < 18 && guard < 200) begin
            #7;
            if (out_valid) begin
                check($sformatf("drain%0d", k), 64'(out_data), 64'(k));
                k++;
            end
            next_cycle();
            guard++;
        end
        check("drain_count", 64'(k), 64'd18);
        #7;
        check("drain_empty", 64'({empty, out_valid, count}), 64'({1'b1, 1'b0, 5'd0}));
        next_cycle();
        out_ready = 1'b0;

        run_stream(40, 1'b0, "stream");
        run_stream(500, 1'b1, "bp");
        repeat (25) begin
            out_ready = 1'b1;
            next_cycle();
        end
        out_ready = 1'b0;

        // Build count=7 with a read in flight, then reset for one cycle.
        k = 0;
        guard = 0;
        while (k < 7 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h70 + k);
            #7;
            if (in_ready) k++;
            next_cycle();
            guard++;
        end
        in_valid = 1'b0;
        repeat (3) next_cycle();
        #7;
        check("mr_settled", 64'(count), 64'd7);
        next_cycle();
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #7;
        check("mr_before", 64'({count, in_ready, sram_csb0, sram_csb1}), 64'({5'd7, 1'b0, 1'b1, 1'b1}));
        next_cycle();
        rst_n = 1'b1;
        #7;
        check("mr_after", 64'({out_valid, count, empty}), 64'({1'b0, 5'd0, 1'b1}));
        next_cycle();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        #7;
        while (!out_valid && guard < 10) begin
            next_cycle();
            #7;
            guard++;
        end
        check("mr_first_valid", 64'(out_valid), 64'd1);
        check("mr_first_data", 64'(out_data), 64'h3C);
        next_cycle();
        out_ready = 1'b0;

        check("no_collision", 64'(coll_errs), 64'd0);
        check("count_limit", 64'(over_errs), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the 16x8 1r1w SRAM macro (sky130_sram_16byte_1r1w_16x8_8). Upstream it accepts valid/ready pushes and issues SRAM writes. It tracks write and read pointers and prefetches SRAM reads into a 2-entry output buffer, so the downstream valid/ready pop interface sustains one word per cycle despite the macro's 1-cycle read latency. The macro's clk0/clk1 are tied to this block's clk at the top level.

Parameters:
DATA_WIDTH, 8, word width; must match the macro.
ADDR_WIDTH, 4, SRAM address width; RAM_DEPTH = 16.
BUF_DEPTH, 2, output prefetch buffer entries; fixed at 2.
COUNT_WIDTH, 5, width of the occupancy count; max value 18.

Ports:
clk  in  1  single clock for all logic and both macro ports.
rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
in_valid  in  1  push request.
in_ready  out  1  push accepted when in_valid & in_ready at posedge.
in_data  in  DATA_WIDTH  push data.
out_valid  out  1  out_data holds the oldest word.
out_ready  in  1  pop when out_valid & out_ready at posedge.
out_data  out  DATA_WIDTH  head of the output buffer.
count  out  COUNT_WIDTH  total words held (SRAM + in-flight + buffer).
full  out  1  equals !in_ready outside reset.
empty  out  1  count == 0.
sram_csb0  out  1  macro write chip select, active low.
sram_addr0  out  ADDR_WIDTH  macro write address.
sram_din0  out  DATA_WIDTH  macro write data.
sram_csb1  out  1  macro read chip select, active low.
sram_addr1  out  ADDR_WIDTH  macro read address.
sram_dout1  in  DATA_WIDTH  macro read data; valid to sample at the edge after the read is captured.

Behaviour:
- Macro timing: inputs are captured at posedge N. A write completes before posedge N+1. Read data (sram_dout1) is sampled by this block at posedge N+1.
- State: wptr, rptr (ADDR_WIDTH, wrap 15->0), mem_count (0..16), rd_inflight (1 bit), 2-entry output buffer with buf_count (0..2).
- in_ready = rst_n & (mem_count < 16).
- push_fire = in_valid & in_ready.
- On push_fire, combinationally in the same cycle: sram_csb0=0, sram_addr0=wptr, sram_din0=in_data. wptr increments at the edge.
- rd_issue = (mem_count != 0) & ((buf_count + rd_inflight) < 2 | pop_fire).
- On rd_issue: sram_csb1=0, sram_addr1=rptr. rptr increments. rd_inflight <= 1 for the next cycle, else 0.
- When rd_inflight=1 at a posedge, sram_dout1 is written into the buffer tail.
- mem_count <= mem_count + push_fire - rd_issue. Simultaneous push and read leaves it unchanged.
- out_valid = (buf_count != 0). pop_fire = out_valid & out_ready. A pop and a buffer fill in the same cycle leave buf_count unchanged.
- count = mem_count + rd_inflight + buf_count. Maximum 18. full/empty are derived combinationally from it.
- Latency: a push accepted at posedge N (with the FIFO otherwise empty) gives out_valid=1 from the cycle beginning at posedge N+2.
- Throughput: with in_valid and out_ready held high, one push and one pop per cycle in steady state.
- Collision freedom: wptr==rptr only when mem_count is 0 (no read issued) or 16 (no push). The same address is therefore never written and read at the same edge. This is required; assert it in the bench.
- Idle outputs: csb0=csb1=1. addr/din hold 0 when the matching csb is high.
- Reset (rst_n=0 at posedge): wptr=rptr=0, mem_count=0, rd_inflight=0, buf_count=0.
  - Outputs: out_valid=0, count=0, empty=1, in_ready=0 while rst_n low, full=0, csb0=csb1=1, addr0=addr1=0, din0=0, out_data=0.
  - Mid-operation reset discards all contents, including any in-flight read (its returning data is ignored). SRAM array contents are not cleared.

Decomposition:
- Package sram_fifo_pkg: DATA_WIDTH, ADDR_WIDTH, RAM_DEPTH, BUF_DEPTH, COUNT_WIDTH constants; typedefs data_t, addr_t, count_t.
- One sub-module: sram_fifo_outbuf. It is the 2-entry synchronous buffer: push from rd_inflight, pop from pop_fire, and it exposes buf_count and the head word.

Test Plan:
- Reset: hold rst_n=0 two cycles -> in_ready=0, out_valid=0, csb0=csb1=1. After release: in_ready=1, count=0, empty=1.
- Single word: push 0xA5 at edge N, out_ready=0 -> csb0=0/addr0=0/din0=0xA5 before N; csb1=0/addr1=0 before N+1; out_valid=1 with out_data=0xA5 from N+2; count=1.
- Fill: push 0x00..0x11 with out_ready=0 -> 18 accepted, then in_ready=0, full=1, count=18, 19th push held. Popping all 18 returns 0x00..0x11 in order; empty=1 at end.
- Streaming: in_valid=out_ready=1 for 40 words 0x40..0x67 -> after latency one pop per cycle, pointers wrap twice, order preserved, no address collision.
- Backpressure: out_ready toggling every cycle plus random in_valid over 500 words -> scoreboard matches exactly, count never exceeds 18.
- Mid-operation reset: count=7 with rd_inflight=1, assert rst_n=0 one cycle -> out_valid=0, count=0. Next pushed 0x3C is the first word popped.
